eeprom_cmd_ctrl: RTL

//  Command sequencer directly upstream of the I2C EEPROM master.
//  - Buffers host read/write byte commands in a small FIFO.
//  - Drives the master's level-held wd_req/rd_req and address/data inputs, one command at a time.
//  - Enforces the EEPROM internal write-cycle time (tWR) after every write.
//  - Returns one response per command on a valid/ready channel.

---
 rtl/eeprom_cmd_ctrl.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/eeprom_cmd_ctrl.sv
// rtl/eeprom_cmd_ctrl.sv - host command FIFO and one-at-a-time sequencer in front of the I2C EEPROM master
// Define EEPROM_WR_VERIFY_EN to read back every write after tWR and flag mismatches on rsp_err.
module eeprom_cmd_ctrl #(
   parameter int FIFO_DEPTH = 4,
   parameter int FIFO_AW    = 2,
   parameter int TWR_CYCLES = 250000,
   parameter int TWR_W      = 18
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic               cmd_rw,
   input  logic [7:0]         cmd_addr,
   input  logic [7:0]         cmd_wdata,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic               rsp_rw,
   output logic [7:0]         rsp_addr,
   output logic [7:0]         rsp_rdata,
   output logic               rsp_err,
   output logic               wd_req,
   output logic               rd_req,
   output logic [7:0]         wr_reg_addr,
   output logic [7:0]         rd_reg_addr,
   output logic [7:0]         wr_data,
   input  logic [7:0]         rd_data,
   input  logic               wr_ack,
   input  logic               rd_ack,
   output logic               busy,
   output logic [FIFO_AW:0]   fifo_level
);

   localparam logic [FIFO_AW:0] LEVEL_FULL = (FIFO_AW+1)'(FIFO_DEPTH);
   localparam logic [TWR_W-1:0] TWR_LAST   = TWR_W'(TWR_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_ISSUE,
      S_TWR,
`ifdef EEPROM_WR_VERIFY_EN
      S_VERIFY,
`endif
      S_RSP
   } state_t;

   logic               fifo_rw    [FIFO_DEPTH];
   logic [7:0]         fifo_addr  [FIFO_DEPTH];
   logic [7:0]         fifo_wdata [FIFO_DEPTH];
   logic [FIFO_AW-1:0] wr_ptr;
   logic [FIFO_AW-1:0] rd_ptr;
   logic               push;
   logic               pop;

   state_t             state;
   logic               cmd_rw_q;
   logic [7:0]         cmd_addr_q;
   logic [7:0]         cmd_wdata_q;
   logic [TWR_W-1:0]   twr_cnt;
   logic               verify_q;
   logic               ack;

   assign cmd_ready = (fifo_level != LEVEL_FULL);
   assign push      = cmd_valid && cmd_ready;
   assign pop       = (state == S_IDLE) && (fifo_level != '0);
   assign ack       = wr_ack | rd_ack;
   assign busy      = (state != S_IDLE) || (fifo_level != '0);
   assign rsp_rw    = cmd_rw_q;
   assign rsp_addr  = cmd_addr_q;

   // Storage needs no reset; validity is tracked by the pointers and level.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_rw[wr_ptr]    <= cmd_rw;
         fifo_addr[wr_ptr]  <= cmd_addr;
         fifo_wdata[wr_ptr] <= cmd_wdata;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_level <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + FIFO_AW'(1);
         if (pop)  rd_ptr <= rd_ptr + FIFO_AW'(1);
         case ({push, pop})
            2'b10:   fifo_level <= fifo_level + (FIFO_AW+1)'(1);
            2'b01:   fifo_level <= fifo_level - (FIFO_AW+1)'(1);
            default: fifo_level <= fifo_level;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= S_IDLE;
         cmd_rw_q    <= 1'b0;
         cmd_addr_q  <= 8'h00;
         cmd_wdata_q <= 8'h00;
         twr_cnt     <= '0;
         verify_q    <= 1'b0;
         wd_req      <= 1'b0;
         rd_req      <= 1'b0;
         wr_reg_addr <= 8'h00;
         rd_reg_addr <= 8'h00;
         wr_data     <= 8'h00;
         rsp_valid   <= 1'b0;
         rsp_rdata   <= 8'h00;
         rsp_err     <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (pop) begin
                  cmd_rw_q    <= fifo_rw[rd_ptr];
                  cmd_addr_q  <= fifo_addr[rd_ptr];
                  cmd_wdata_q <= fifo_wdata[rd_ptr];
                  if (fifo_rw[rd_ptr]) begin
                     rd_reg_addr <= fifo_addr[rd_ptr];
                  end else begin
                     wr_reg_addr <= fifo_addr[rd_ptr];
                     wr_data     <= fifo_wdata[rd_ptr];
                  end
                  state <= S_LOAD;
               end
            end

            // Address/data settle one cycle ahead of the request level.
            S_LOAD: begin
               wd_req <= !cmd_rw_q;
               rd_req <= cmd_rw_q;
               state  <= S_ISSUE;
            end

            S_ISSUE: begin
               if (ack) begin
                  wd_req <= 1'b0;
                  rd_req <= 1'b0;
                  if (cmd_rw_q || verify_q) begin
                     rsp_rdata <= rd_data;
                     rsp_err   <= verify_q && (rd_data != cmd_wdata_q);
                     rsp_valid <= 1'b1;
                     state     <= S_RSP;
                  end else begin
                     twr_cnt <= '0;
                     state   <= S_TWR;
                  end
               end
            end

            S_TWR: begin
               if (twr_cnt == TWR_LAST) begin
`ifdef EEPROM_WR_VERIFY_EN
                  rd_reg_addr <= cmd_addr_q;
                  verify_q    <= 1'b1;
                  state       <= S_VERIFY;
`else
                  rsp_rdata   <= 8'h00;
                  rsp_err     <= 1'b0;
                  rsp_valid   <= 1'b1;
                  state       <= S_RSP;
`endif
               end else begin
                  twr_cnt <= twr_cnt + TWR_W'(1);
               end
            end

`ifdef EEPROM_WR_VERIFY_EN
            // Read-back reuses the ISSUE handshake with the read request.
            S_VERIFY: begin
               rd_req <= 1'b1;
               state  <= S_ISSUE;
            end
`endif

            S_RSP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  verify_q  <= 1'b0;
                  state     <= S_IDLE;
               end
            end

            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
